// File: rtl/axi_out_txn_guard.sv
// axi_out_txn_guard
//
// Outbound AXI transaction guard for the host-facing port of the secure
// subsystem. All AXI channels pass through with zero latency. The guard
// counts outstanding writes and reads, closes the AW/AR address channels
// when a direction reaches MaxTxn outstanding, and latches a sticky
// per-direction timeout when a started transaction stops getting responses.
//
// Ports:
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   slv_req_i         AXI request from upstream (data-width converter)
//   slv_resp_o        AXI response to upstream
//   mst_req_o         AXI request to downstream (isolation stage)
//   mst_resp_i        AXI response from downstream
//   clear_i           one-cycle pulse, clears timeout_o and protocol_err_o
//   wr_outstanding_o  outstanding write count
//   rd_outstanding_o  outstanding read count (reads + atomics with R response)
//   timeout_o         sticky timeout flags, bit 0 write, bit 1 read
//   protocol_err_o    sticky flag, response seen with nothing outstanding

package synth_axi_out_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  atop;
    } synth_axi_out_aw_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } synth_axi_out_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } synth_axi_out_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } synth_axi_out_ar_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } synth_axi_out_r_t;

    typedef struct packed {
        synth_axi_out_aw_t aw;
        logic              aw_valid;
        synth_axi_out_w_t  w;
        logic              w_valid;
        logic              b_ready;
        synth_axi_out_ar_t ar;
        logic              ar_valid;
        logic              r_ready;
    } synth_axi_out_req_t;

    typedef struct packed {
        logic             aw_ready;
        logic             ar_ready;
        logic             w_ready;
        synth_axi_out_b_t b;
        logic             b_valid;
        synth_axi_out_r_t r;
        logic             r_valid;
    } synth_axi_out_resp_t;

endpackage

module axi_out_txn_guard
    import synth_axi_out_pkg::*;
#(
    parameter int unsigned MaxTxn        = 8,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntWidth      = $clog2(MaxTxn + 1),
    parameter int unsigned TmrWidth      = $clog2(TimeoutCycles),
    parameter type axi_req_t             = synth_axi_out_req_t,
    parameter type axi_resp_t            = synth_axi_out_resp_t
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  axi_req_t            slv_req_i,
    output axi_resp_t           slv_resp_o,
    output axi_req_t            mst_req_o,
    input  axi_resp_t           mst_resp_i,
    input  logic                clear_i,
    output logic [CntWidth-1:0] wr_outstanding_o,
    output logic [CntWidth-1:0] rd_outstanding_o,
    output logic [1:0]          timeout_o,
    output logic                protocol_err_o
);

    localparam logic [CntWidth-1:0] MAX_CNT = CntWidth'(MaxTxn);
    localparam logic [CntWidth:0]   MAX_EXT = (CntWidth + 1)'(MaxTxn);
    localparam logic [CntWidth:0]   ONE_EXT = (CntWidth + 1)'(1);
    localparam logic [TmrWidth-1:0] TMR_MAX = TmrWidth'(TimeoutCycles - 1);
    localparam logic [TmrWidth-1:0] TMR_ONE = TmrWidth'(1);

    logic [CntWidth-1:0] wr_cnt, rd_cnt;
    logic [CntWidth-1:0] wr_cnt_nxt, rd_cnt_nxt;
    logic [CntWidth:0]   wr_ext, rd_ext;
    logic [TmrWidth-1:0] wr_tmr, rd_tmr;
    logic [1:0]          timeout_q;
    logic                perr_q;

    logic aw_open, ar_open;
    logic aw_hs, b_hs, ar_hs, r_beat, r_hs, atomic_hs;
    logic wr_uf, rd_uf;
    logic wr_to_set, rd_to_set;

    // Gates depend only on registered state, so no ready-to-valid path exists.
    assign aw_open = (wr_cnt < MAX_CNT) & ~timeout_q[0];
    assign ar_open = (rd_cnt < MAX_CNT) & ~timeout_q[1];

    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_open;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_open;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open;
    end

    assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign r_beat    = mst_resp_i.r_valid & slv_req_i.r_ready;
    assign r_hs      = r_beat & mst_resp_i.r.last;
    // Atomics with atop[5] set return read data, so they also occupy a read slot.
    assign atomic_hs = aw_hs & slv_req_i.aw.atop[5];

    assign wr_uf = b_hs & (wr_cnt == '0);
    assign rd_uf = r_hs & (rd_cnt == '0);

    // A decrement that would underflow is dropped; the error flag records it.
    always_comb begin
        wr_ext = {1'b0, wr_cnt} + {{CntWidth{1'b0}}, aw_hs};
        if (b_hs && !wr_uf) begin
            wr_ext = wr_ext - ONE_EXT;
        end
        if (wr_ext > MAX_EXT) begin
            wr_ext = MAX_EXT;
        end
        wr_cnt_nxt = wr_ext[CntWidth-1:0];

        rd_ext = {1'b0, rd_cnt} + {{CntWidth{1'b0}}, ar_hs}
               + {{CntWidth{1'b0}}, atomic_hs};
        if (r_hs && !rd_uf) begin
            rd_ext = rd_ext - ONE_EXT;
        end
        if (rd_ext > MAX_EXT) begin
            rd_ext = MAX_EXT;
        end
        rd_cnt_nxt = rd_ext[CntWidth-1:0];
    end

    assign wr_to_set = (wr_tmr == TMR_MAX) & (wr_cnt != '0) & ~b_hs;
    assign rd_to_set = (rd_tmr == TMR_MAX) & (rd_cnt != '0) & ~r_beat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wr_tmr    <= '0;
            rd_tmr    <= '0;
            timeout_q <= 2'b00;
            perr_q    <= 1'b0;
        end else begin
            wr_cnt <= wr_cnt_nxt;
            rd_cnt <= rd_cnt_nxt;

            if ((wr_cnt == '0) || b_hs) begin
                wr_tmr <= '0;
            end else if (wr_tmr != TMR_MAX) begin
                wr_tmr <= wr_tmr + TMR_ONE;
            end

            // Any R beat counts as progress, not only the last one.
            if ((rd_cnt == '0) || r_beat) begin
                rd_tmr <= '0;
            end else if (rd_tmr != TMR_MAX) begin
                rd_tmr <= rd_tmr + TMR_ONE;
            end

            // Set has priority over clear so a coincident event is never lost.
            if (wr_to_set) begin
                timeout_q[0] <= 1'b1;
            end else if (clear_i) begin
                timeout_q[0] <= 1'b0;
            end

            if (rd_to_set) begin
                timeout_q[1] <= 1'b1;
            end else if (clear_i) begin
                timeout_q[1] <= 1'b0;
            end

            if (wr_uf || rd_uf) begin
                perr_q <= 1'b1;
            end else if (clear_i) begin
                perr_q <= 1'b0;
            end
        end
    end

    assign wr_outstanding_o = wr_cnt;
    assign rd_outstanding_o = rd_cnt;
    assign timeout_o        = timeout_q;
    assign protocol_err_o   = perr_q;

endmodule

// File: tb/tb_axi_out_txn_guard.sv
module tb_axi_out_txn_guard;
    import synth_axi_out_pkg::*;

    localparam int MT = 8;
    localparam int TC = 16;

    logic                clk;
    logic                rst;
    logic                clear;
    synth_axi_out_req_t  slv_req;
    synth_axi_out_req_t  mst_req;
    synth_axi_out_resp_t slv_resp;
    synth_axi_out_resp_t mst_resp;
    logic [3:0]          wr_out;
    logic [3:0]          rd_out;
    logic [1:0]          to;
    logic                perr;

    int total = 0;
    int bad   = 0;

    axi_out_txn_guard #(
        .MaxTxn        (MT),
        .TimeoutCycles (TC)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .slv_req_i        (slv_req),
        .slv_resp_o       (slv_resp),
        .mst_req_o        (mst_req),
        .mst_resp_i       (mst_resp),
        .clear_i          (clear),
        .wr_outstanding_o (wr_out),
        .rd_outstanding_o (rd_out),
        .timeout_o        (to),
        .protocol_err_o   (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        slv_req         = '0;
        slv_req.b_ready = 1'b1;
        slv_req.r_ready = 1'b1;
        mst_resp        = '0;
        clear           = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick(2);
        rst = 1'b0;
        total++; if (wr_out !== 4'd0) begin bad++; $display("FAIL reset_wr act=%0d exp=0", wr_out); end
        total++; if (rd_out !== 4'd0) begin bad++; $display("FAIL reset_rd act=%0d exp=0", rd_out); end
        total++; if (to !== 2'b00) begin bad++; $display("FAIL reset_to act=%b exp=00", to); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL reset_perr act=%b exp=0", perr); end
        slv_req.aw_valid = 1'b1;
        slv_req.ar_valid = 1'b1;
        #1;
        total++; if (mst_req.aw_valid !== 1'b1) begin bad++; $display("FAIL reset_aw_open act=%b exp=1", mst_req.aw_valid); end
        total++; if (mst_req.ar_valid !== 1'b1) begin bad++; $display("FAIL reset_ar_open act=%b exp=1", mst_req.ar_valid); end
        idle();
        tick();
    endtask

    task automatic test_passthrough();
        idle();
        slv_req.w.data  = 64'hDEAD_BEEF_0123_4567;
        slv_req.w_valid = 1'b1;
        mst_resp.r.data = 64'h0000_0000_0000_0055;
        mst_resp.w_ready = 1'b1;
        #1;
        total++; if (mst_req.w.data !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL pass_wdata act=%h exp=deadbeef01234567", mst_req.w.data); end
        total++; if (mst_req.w_valid !== 1'b1) begin bad++; $display("FAIL pass_wvalid act=%b exp=1", mst_req.w_valid); end
        total++; if (slv_resp.r.data !== 64'h55) begin bad++; $display("FAIL pass_rdata act=%h exp=55", slv_resp.r.data); end
        total++; if (slv_resp.w_ready !== 1'b1) begin bad++; $display("FAIL pass_wready act=%b exp=1", slv_resp.w_ready); end
        idle();
        tick();
    endtask

    task automatic test_limit();
        idle();
        slv_req.aw_valid   = 1'b1;
        mst_resp.aw_ready  = 1'b1;
        tick(8);
        total++; if (wr_out !== 4'd8) begin bad++; $display("FAIL limit_cnt8 act=%0d exp=8", wr_out); end
        total++; if (mst_req.aw_valid !== 1'b0) begin bad++; $display("FAIL limit_mst_awvalid act=%b exp=0", mst_req.aw_valid); end
        total++; if (slv_resp.aw_ready !== 1'b0) begin bad++; $display("FAIL limit_slv_awready act=%b exp=0", slv_resp.aw_ready); end
        mst_resp.b_valid = 1'b1;
        #1;
        total++; if (mst_req.aw_valid !== 1'b0) begin bad++; $display("FAIL limit_closed_in_b act=%b exp=0", mst_req.aw_valid); end
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        total++; if (wr_out !== 4'd7) begin bad++; $display("FAIL limit_cnt7 act=%0d exp=7", wr_out); end
        total++; if (mst_req.aw_valid !== 1'b1) begin bad++; $display("FAIL limit_reopen_valid act=%b exp=1", mst_req.aw_valid); end
        total++; if (slv_resp.aw_ready !== 1'b1) begin bad++; $display("FAIL limit_reopen_ready act=%b exp=1", slv_resp.aw_ready); end
        tick();
        total++; if (wr_out !== 4'd8) begin bad++; $display("FAIL limit_ninth act=%0d exp=8", wr_out); end
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        tick(8);
        mst_resp.b_valid = 1'b0;
        total++; if (wr_out !== 4'd0) begin bad++; $display("FAIL limit_drain act=%0d exp=0", wr_out); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL limit_perr act=%b exp=0", perr); end
        total++; if (to !== 2'b00) begin bad++; $display("FAIL limit_to act=%b exp=00", to); end
        idle();
    endtask

    task automatic test_timeout();
        idle();
        slv_req.ar_valid  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        tick();
        slv_req.ar_valid = 1'b0;
        total++; if (rd_out !== 4'd1) begin bad++; $display("FAIL to_rd1 act=%0d exp=1", rd_out); end
        tick(15);
        total++; if (to !== 2'b00) begin bad++; $display("FAIL to_early act=%b exp=00", to); end
        tick();
        total++; if (to !== 2'b10) begin bad++; $display("FAIL to_set act=%b exp=10", to); end
        slv_req.ar_valid = 1'b1;
        #1;
        total++; if (mst_req.ar_valid !== 1'b0) begin bad++; $display("FAIL to_ar_blocked act=%b exp=0", mst_req.ar_valid); end
        total++; if (slv_resp.ar_ready !== 1'b0) begin bad++; $display("FAIL to_arready_blocked act=%b exp=0", slv_resp.ar_ready); end
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        tick();
        mst_resp.r_valid = 1'b0;
        mst_resp.r.last  = 1'b0;
        #1;
        total++; if (rd_out !== 4'd0) begin bad++; $display("FAIL to_drain act=%0d exp=0", rd_out); end
        total++; if (mst_req.ar_valid !== 1'b0) begin bad++; $display("FAIL to_still_blocked act=%b exp=0", mst_req.ar_valid); end
        total++; if (to !== 2'b10) begin bad++; $display("FAIL to_sticky act=%b exp=10", to); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        total++; if (to !== 2'b00) begin bad++; $display("FAIL to_cleared act=%b exp=00", to); end
        total++; if (mst_req.ar_valid !== 1'b1) begin bad++; $display("FAIL to_ar_open act=%b exp=1", mst_req.ar_valid); end
        tick();
        slv_req.ar_valid = 1'b0;
        total++; if (rd_out !== 4'd1) begin bad++; $display("FAIL to_ar_accepted act=%0d exp=1", rd_out); end
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        tick();
        idle();
        total++; if (rd_out !== 4'd0) begin bad++; $display("FAIL to_final_rd act=%0d exp=0", rd_out); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL to_perr act=%b exp=0", perr); end
    endtask

    task automatic test_r_beats();
        idle();
        slv_req.ar_valid  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        tick();
        slv_req.ar_valid = 1'b0;
        tick(9);
        mst_resp.r_valid = 1'b1;
        tick();
        mst_resp.r_valid = 1'b0;
        tick(9);
        total++; if (to !== 2'b00) begin bad++; $display("FAIL rbeat_no_to act=%b exp=00", to); end
        total++; if (rd_out !== 4'd1) begin bad++; $display("FAIL rbeat_rd act=%0d exp=1", rd_out); end
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        tick();
        idle();
        total++; if (rd_out !== 4'd0) begin bad++; $display("FAIL rbeat_drain act=%0d exp=0", rd_out); end
    endtask

    task automatic test_back_to_back();
        idle();
        slv_req.aw_valid  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        tick(3);
        slv_req.aw_valid = 1'b0;
        total++; if (wr_out !== 4'd3) begin bad++; $display("FAIL b2b_cnt3 act=%0d exp=3", wr_out); end
        tick(8);
        slv_req.aw_valid = 1'b1;
        mst_resp.b_valid = 1'b1;
        tick();
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b0;
        total++; if (wr_out !== 4'd3) begin bad++; $display("FAIL b2b_hold act=%0d exp=3", wr_out); end
        tick(15);
        total++; if (to !== 2'b00) begin bad++; $display("FAIL b2b_tmr_reset act=%b exp=00", to); end
        tick();
        total++; if (to !== 2'b01) begin bad++; $display("FAIL b2b_to_set act=%b exp=01", to); end
        slv_req.aw_valid = 1'b1;
        #1;
        total++; if (mst_req.aw_valid !== 1'b0) begin bad++; $display("FAIL b2b_aw_blocked act=%b exp=0", mst_req.aw_valid); end
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        tick(3);
        mst_resp.b_valid = 1'b0;
        total++; if (wr_out !== 4'd0) begin bad++; $display("FAIL b2b_drain act=%0d exp=0", wr_out); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL b2b_perr act=%b exp=0", perr); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (to !== 2'b00) begin bad++; $display("FAIL b2b_clear act=%b exp=00", to); end
        idle();
    endtask

    task automatic test_atomic();
        idle();
        slv_req.aw_valid  = 1'b1;
        slv_req.aw.atop   = 6'b100000;
        mst_resp.aw_ready = 1'b1;
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.aw.atop  = 6'b000000;
        total++; if (wr_out !== 4'd1) begin bad++; $display("FAIL atomic_wr act=%0d exp=1", wr_out); end
        total++; if (rd_out !== 4'd1) begin bad++; $display("FAIL atomic_rd act=%0d exp=1", rd_out); end
        mst_resp.b_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        total++; if (wr_out !== 4'd0) begin bad++; $display("FAIL atomic_b act=%0d exp=0", wr_out); end
        total++; if (rd_out !== 4'd1) begin bad++; $display("FAIL atomic_rd_hold act=%0d exp=1", rd_out); end
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        tick();
        mst_resp.r_valid = 1'b0;
        mst_resp.r.last  = 1'b0;
        total++; if (rd_out !== 4'd0) begin bad++; $display("FAIL atomic_r act=%0d exp=0", rd_out); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL atomic_perr act=%b exp=0", perr); end
        slv_req.aw_valid = 1'b1;
        slv_req.aw.atop  = 6'b011111;
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.aw.atop  = 6'b000000;
        total++; if (rd_out !== 4'd0) begin bad++; $display("FAIL atomic_nonr_rd act=%0d exp=0", rd_out); end
        total++; if (wr_out !== 4'd1) begin bad++; $display("FAIL atomic_nonr_wr act=%0d exp=1", wr_out); end
        mst_resp.b_valid = 1'b1;
        tick();
        idle();
        total++; if (wr_out !== 4'd0) begin bad++; $display("FAIL atomic_nonr_b act=%0d exp=0", wr_out); end
    endtask

    task automatic test_underflow();
        idle();
        mst_resp.b_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        total++; if (perr !== 1'b1) begin bad++; $display("FAIL uf_b_perr act=%b exp=1", perr); end
        total++; if (wr_out !== 4'd0) begin bad++; $display("FAIL uf_b_cnt act=%0d exp=0", wr_out); end
        mst_resp.b_valid = 1'b1;
        clear = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        clear = 1'b0;
        total++; if (perr !== 1'b1) begin bad++; $display("FAIL uf_set_wins act=%b exp=1", perr); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL uf_clear act=%b exp=0", perr); end
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        tick();
        mst_resp.r_valid = 1'b0;
        mst_resp.r.last  = 1'b0;
        total++; if (perr !== 1'b1) begin bad++; $display("FAIL uf_r_perr act=%b exp=1", perr); end
        total++; if (rd_out !== 4'd0) begin bad++; $display("FAIL uf_r_cnt act=%0d exp=0", rd_out); end
        clear = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        slv_req.aw_valid  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        tick(4);
        slv_req.aw_valid = 1'b0;
        total++; if (wr_out !== 4'd4) begin bad++; $display("FAIL rstmid_cnt4 act=%0d exp=4", wr_out); end
        tick(7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mst_resp.aw_ready = 1'b0;
        slv_req.aw_valid  = 1'b1;
        #1;
        total++; if (wr_out !== 4'd0) begin bad++; $display("FAIL rstmid_wr act=%0d exp=0", wr_out); end
        total++; if (rd_out !== 4'd0) begin bad++; $display("FAIL rstmid_rd act=%0d exp=0", rd_out); end
        total++; if (to !== 2'b00) begin bad++; $display("FAIL rstmid_to act=%b exp=00", to); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL rstmid_perr act=%b exp=0", perr); end
        total++; if (mst_req.aw_valid !== 1'b1) begin bad++; $display("FAIL rstmid_aw_open act=%b exp=1", mst_req.aw_valid); end
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        total++; if (perr !== 1'b1) begin bad++; $display("FAIL rstmid_late_b act=%b exp=1", perr); end
        total++; if (wr_out !== 4'd0) begin bad++; $display("FAIL rstmid_late_cnt act=%0d exp=0", wr_out); end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_passthrough();
        test_limit();
        test_timeout();
        test_r_beats();
        test_back_to_back();
        test_atomic();
        test_underflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
